hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 16 +
 rtl/sat_counter.sv | 37 +++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
// Purpose: state enum and default widths used by hazard_ctrl and its bench.
// Ports: none (package).
package hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL   = 2'd1,
    MEM_WAIT   = 2'd2,
    REDIR_PEND = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Purpose: counts cycles with inc=1 and holds at all-ones.
// Ports: clk, rstn (sync, active-high clear), inc (count enable),
//        cnt (current count, CNT_W bits).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/redirect controller
// Purpose: resolves memory freeze, branch redirect and load-use hazards into
//          per-stage write enables and flushes; counts stall and redirect cycles.
// Ports: clk, rstn (sync, active-high reset);
//        id_rs1/id_rs2/id_use_rs1/id_use_rs2 (ID-stage sources),
//        ex_memread/ex_rd (EX-stage load), ex_redirect (EX branch/jump taken),
//        dmem_busy (freeze request);
//        pc_write/ifid_write/idex_write/exmem_write (stage enables),
//        ifid_flush/idex_flush (bubbles), redirect_take (PC mux select),
//        stall_cnt/flush_cnt (saturating counters).
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              redirect_take,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e state_q;
  state_e state_d;
  logic   luh;
  logic   redir_now;

  assign luh = ex_memread && (ex_rd != '0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) ||
                (id_use_rs2 && (ex_rd == id_rs2)));

  // A redirect is served either from the live pulse or from the one held
  // across a memory freeze.
  assign redir_now = ex_redirect || (state_q == REDIR_PEND);

  always_comb begin
    state_d       = RUN;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    exmem_write   = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    redirect_take = 1'b0;

    if (rstn) begin
      state_d = RUN;
    end else if (dmem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = redir_now ? REDIR_PEND : MEM_WAIT;
    end else if (redir_now) begin
      // ifid_write stays 1 so a flush never meets a held stage register.
      redirect_take = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
    end else if (state_q == LU_STALL) begin
      // The stalled instruction sees the load result now; do not re-check luh
      // on inputs that have not advanced.
      state_d = RUN;
    end else if (luh) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_d    = LU_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (~pc_write),
    .cnt  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (redirect_take),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_redirect, dmem_busy;

  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_flush, redirect_take;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_write4, ifid_write4, idex_write4, exmem_write4;
  logic        ifid_flush4, idex_flush4, redirect_take4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  logic [6:0] outs, outs4;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending redirect, previous cycle was a load-use stall,
  // and plain integer event counts.
  bit m_pend, m_lu;
  int m_stall, m_flush, m_stall4, m_flush4;

  localparam logic [6:0] O_NORM  = 7'b1111000;
  localparam logic [6:0] O_FREEZ = 7'b0000000;
  localparam logic [6:0] O_REDIR = 7'b1111111;
  localparam logic [6:0] O_LU    = 7'b0011010;

  always #5 clk = ~clk;

  assign outs  = {pc_write, ifid_write, idex_write, exmem_write,
                  ifid_flush, idex_flush, redirect_take};
  assign outs4 = {pc_write4, ifid_write4, idex_write4, exmem_write4,
                  ifid_flush4, idex_flush4, redirect_take4};

  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) u_dut (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .redirect_take(redirect_take), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .idex_write(idex_write4),
    .exmem_write(exmem_write4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .redirect_take(redirect_take4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  function automatic bit luh_now();
    return ex_memread && (ex_rd != 0) &&
           ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
  endfunction

  function automatic logic [6:0] model_out();
    if (rstn) return O_NORM;
    if (dmem_busy) return O_FREEZ;
    if (ex_redirect || m_pend) return O_REDIR;
    if (!m_lu && luh_now()) return O_LU;
    return O_NORM;
  endfunction

  task automatic tick();
    logic [6:0] e;
    bit n_pend, n_lu;
    e = model_out();
    n_pend = !rstn && dmem_busy && (ex_redirect || m_pend);
    n_lu   = !rstn && (e == O_LU);
    @(posedge clk);
    if (rstn) begin
      m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    end else begin
      if (!e[6]) begin
        m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (e[0]) begin
        m_flush++;
        if (m_flush4 < 15) m_flush4++;
      end
    end
    m_pend = n_pend;
    m_lu   = n_lu;
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_redirect = 0; dmem_busy = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    idle_inputs();
    tick();
    tick();
    rstn = 1'b0;
  endtask

  task automatic set_luh_inputs(input logic [4:0] rd);
    ex_memread = 1; ex_rd = rd; id_rs1 = 5; id_use_rs1 = 1;
    id_rs2 = 9; id_use_rs2 = 1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    idle_inputs();
    dmem_busy = 1; ex_redirect = 1; set_luh_inputs(5);
    #3;
    total++;
    if (outs !== O_NORM) begin bad++; $display("FAIL reset_outputs: got %b want %b", outs, O_NORM); end
    tick();
    total++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      bad++; $display("FAIL reset_counters: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
    tick();
    rstn = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    set_luh_inputs(5);
    #3;
    total++;
    if (outs !== O_LU) begin bad++; $display("FAIL lu_stall_cycle: got %b want %b", outs, O_LU); end
    tick();
    #3;
    total++;
    if (outs !== O_NORM) begin bad++; $display("FAIL lu_after_stall: got %b want %b", outs, O_NORM); end
    total++;
    if (stall_cnt !== 1) begin bad++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
    #3;
    total++;
    if (outs !== O_LU) begin bad++; $display("FAIL lu_reeval: got %b want %b", outs, O_LU); end
    tick();
  endtask

  task automatic test_rd_zero();
    do_reset();
    set_luh_inputs(0);
    id_rs1 = 0;
    #3;
    total++;
    if (outs !== O_NORM) begin bad++; $display("FAIL rd0_no_stall: got %b want %b", outs, O_NORM); end
    tick();
    #3;
    total++;
    if (stall_cnt !== 0) begin bad++; $display("FAIL rd0_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    ex_redirect = 1;
    #3;
    total++;
    if (outs !== O_REDIR) begin bad++; $display("FAIL redirect_same_cycle: got %b want %b", outs, O_REDIR); end
    tick();
    ex_redirect = 0;
    #3;
    total++;
    if (outs !== O_NORM || flush_cnt !== 1) begin
      bad++; $display("FAIL redirect_after: got %b flush=%0d want %b flush=1", outs, flush_cnt, O_NORM);
    end
  endtask

  task automatic test_busy_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dmem_busy = 1; ex_redirect = (i == 0);
      #3;
      total++;
      if (outs !== O_FREEZ) begin bad++; $display("FAIL busy_freeze%0d: got %b want %b", i, outs, O_FREEZ); end
      tick();
    end
    dmem_busy = 0; ex_redirect = 0;
    #3;
    total++;
    if (outs !== O_REDIR) begin bad++; $display("FAIL busy_pending_take: got %b want %b", outs, O_REDIR); end
    tick();
    #3;
    total++;
    if (outs !== O_NORM) begin bad++; $display("FAIL busy_take_once: got %b want %b", outs, O_NORM); end
    total++;
    if (stall_cnt !== 3 || flush_cnt !== 1) begin
      bad++; $display("FAIL busy_counters: got stall=%0d flush=%0d want 3 1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_redirect_luh();
    do_reset();
    set_luh_inputs(5);
    ex_redirect = 1;
    #3;
    total++;
    if (outs !== O_REDIR) begin bad++; $display("FAIL redir_beats_luh: got %b want %b", outs, O_REDIR); end
    tick();
    idle_inputs();
    #3;
    total++;
    if (stall_cnt !== 0 || flush_cnt !== 1) begin
      bad++; $display("FAIL redir_luh_counters: got stall=%0d flush=%0d want 0 1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    dmem_busy = 1; ex_redirect = 1;
    tick();
    ex_redirect = 0;
    tick();
    rstn = 1; dmem_busy = 0;
    #3;
    total++;
    if (outs !== O_NORM) begin bad++; $display("FAIL rst_pend_during: got %b want %b", outs, O_NORM); end
    tick();
    rstn = 0;
    for (int i = 0; i < 2; i++) begin
      #3;
      total++;
      if (outs !== O_NORM) begin bad++; $display("FAIL rst_pend_no_take%0d: got %b want %b", i, outs, O_NORM); end
      tick();
    end
    total++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      bad++; $display("FAIL rst_pend_counters: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_busy = 1;
    for (int i = 0; i < 20; i++) tick();
    dmem_busy = 0;
    #3;
    total++;
    if (stall_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_cnt4: got %0d want 15", stall_cnt4); end
    total++;
    if (stall_cnt !== 20) begin bad++; $display("FAIL sat_cnt32: got %0d want 20", stall_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rstn        = ($urandom_range(0, 49) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_memread  = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 7) == 0);
      dmem_busy   = ($urandom_range(0, 4) == 0);
      #3;
      total++;
      if (outs !== model_out() || outs4 !== model_out()) begin
        bad++; $display("FAIL rand_outs[%0d]: got %b/%b want %b", i, outs, outs4, model_out());
      end
      total++;
      if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush) ||
          stall_cnt4 !== 4'(m_stall4) || flush_cnt4 !== 4'(m_flush4)) begin
        bad++;
        $display("FAIL rand_cnt[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                 stall_cnt, flush_cnt, stall_cnt4, flush_cnt4, m_stall, m_flush, m_stall4, m_flush4);
      end
      tick();
    end
    rstn = 0;
  endtask

  initial begin
    m_pend = 0; m_lu = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_redirect();
    test_busy_redirect();
    test_redirect_luh();
    test_reset_pending();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
